// File: rtl/img_pipe_pkg.sv
// Shared types and constants for the image pipeline sequencer and its helpers.
package img_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD        = 3'd1,
    ST_START_GRAY  = 3'd2,
    ST_RUN_GRAY    = 3'd3,
    ST_START_SOBEL = 3'd4,
    ST_RUN_SOBEL   = 3'd5,
    ST_DONE        = 3'd6,
    ST_ERR         = 3'd7
  } seq_state_t;

  localparam logic [1:0] ACC_HOST  = 2'b00;
  localparam logic [1:0] ACC_GRAY  = 2'b01;
  localparam logic [1:0] ACC_SOBEL = 2'b10;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;

  // BRAM owner for each state; only the processing stages take the port away from the host.
  function automatic logic [1:0] access_for(input seq_state_t s);
    case (s)
      ST_START_GRAY, ST_RUN_GRAY:   return ACC_GRAY;
      ST_START_SOBEL, ST_RUN_SOBEL: return ACC_SOBEL;
      default:                      return ACC_HOST;
    endcase
  endfunction

  function automatic logic is_busy(input seq_state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/pipe_watchdog.sv
// Stage watchdog: counts enabled cycles since the last clear and flags the last allowed cycle once.
module pipe_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             fired;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      fired <= 1'b0;
    end else if (enable) begin
      if (count != LAST) count <= count + CNT_W'(1);
      if (expire)        fired <= 1'b1;
    end
  end

  assign expire = enable && !fired && (count == LAST);

endmodule

// File: rtl/img_pipe_sequencer.sv
// Sequences color load, RGB->gray and gray->Sobel stages, arbitrating BRAM ownership with a per-stage watchdog.
module img_pipe_sequencer
  import img_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048575,
  parameter int unsigned CYC_W          = 24
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_START,
  input  logic             i_ABORT,
  input  logic             i_COLOR_LOADED,
  input  logic             i_GRAY_DONE,
  input  logic             i_SOBEL_DONE,
  output logic [1:0]       o_ACCESS_CONTROL,
  output logic             o_START_RGB2GRAY,
  output logic             o_START_GRAY2SOBEL,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic             o_ERROR,
  output logic             o_ERR_STAGE,
  output logic [2:0]       o_STATE,
  output logic [CYC_W-1:0] o_CYCLES
);

  seq_state_t state, state_d;
  logic       gray_prev, sobel_prev;
  logic       gray_edge, sobel_edge;
  logic       in_run, counting, start_ok, wd_expire;

  assign gray_edge  = i_GRAY_DONE  && !gray_prev;
  assign sobel_edge = i_SOBEL_DONE && !sobel_prev;
  assign in_run     = (state == ST_RUN_GRAY) || (state == ST_RUN_SOBEL);
  assign counting   = state inside {ST_START_GRAY, ST_RUN_GRAY, ST_START_SOBEL, ST_RUN_SOBEL};

  // Leaving a RUN state always passes through a non-RUN state, so holding clear outside RUN restarts the count per stage.
  pipe_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (i_CLK),
    .rst    (i_RST),
    .clear  (!in_run),
    .enable (in_run),
    .expire (wd_expire)
  );

  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    if (i_ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_START) begin
            state_d  = ST_LOAD;
            start_ok = 1'b1;
          end
        end
        ST_LOAD:        if (i_COLOR_LOADED) state_d = ST_START_GRAY;
        ST_START_GRAY:  state_d = ST_RUN_GRAY;
        ST_RUN_GRAY: begin
          if (gray_edge)      state_d = ST_START_SOBEL;
          else if (wd_expire) state_d = ST_ERR;
        end
        ST_START_SOBEL: state_d = ST_RUN_SOBEL;
        ST_RUN_SOBEL: begin
          if (sobel_edge)     state_d = ST_DONE;
          else if (wd_expire) state_d = ST_ERR;
        end
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state              <= ST_IDLE;
      gray_prev          <= 1'b0;
      sobel_prev         <= 1'b0;
      o_ACCESS_CONTROL   <= ACC_HOST;
      o_START_RGB2GRAY   <= 1'b0;
      o_START_GRAY2SOBEL <= 1'b0;
      o_BUSY             <= 1'b0;
      o_DONE             <= 1'b0;
      o_ERROR            <= 1'b0;
      o_ERR_STAGE        <= 1'b0;
      o_STATE            <= ST_IDLE;
      o_CYCLES           <= '0;
    end else begin
      state              <= state_d;
      gray_prev          <= i_GRAY_DONE;
      sobel_prev         <= i_SOBEL_DONE;
      o_ACCESS_CONTROL   <= access_for(state_d);
      o_START_RGB2GRAY   <= (state_d == ST_START_GRAY);
      o_START_GRAY2SOBEL <= (state_d == ST_START_SOBEL);
      o_BUSY             <= is_busy(state_d);
      o_DONE             <= (state_d == ST_DONE);
      o_ERROR            <= (state_d == ST_ERR);
      o_STATE            <= state_d;
      if (state_d != ST_ERR)      o_ERR_STAGE <= 1'b0;
      else if (state != ST_ERR)   o_ERR_STAGE <= (state == ST_RUN_SOBEL);
      if (start_ok)                          o_CYCLES <= '0;
      else if (counting && o_CYCLES != '1)   o_CYCLES <= o_CYCLES + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_img_pipe_sequencer.sv
// Randomized self-checking bench for img_pipe_sequencer against a job-level timing model.
module tb_img_pipe_sequencer;
  import img_pipe_pkg::*;

  localparam int unsigned TO   = 100;
  localparam int unsigned CW   = 7;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, abort, color_loaded, gray_done, sobel_done;
  logic [1:0]    o_access;
  logic          o_rgb, o_sob, o_busy, o_done, o_err, o_err_stage;
  logic [2:0]    o_state;
  logic [CW-1:0] o_cycles;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_rgb, n_sob, n_chg;
  logic [31:0] acc_hist;
  logic [1:0]  last_acc = 2'b00;

  always #5 clk = ~clk;

  img_pipe_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CYC_W(CW)
  ) dut (
    .i_CLK              (clk),
    .i_RST              (rst),
    .i_START            (start),
    .i_ABORT            (abort),
    .i_COLOR_LOADED     (color_loaded),
    .i_GRAY_DONE        (gray_done),
    .i_SOBEL_DONE       (sobel_done),
    .o_ACCESS_CONTROL   (o_access),
    .o_START_RGB2GRAY   (o_rgb),
    .o_START_GRAY2SOBEL (o_sob),
    .o_BUSY             (o_busy),
    .o_DONE             (o_done),
    .o_ERROR            (o_err),
    .o_ERR_STAGE        (o_err_stage),
    .o_STATE            (o_state),
    .o_CYCLES           (o_cycles)
  );

  // Pulse counts and the history of BRAM owners seen on the bus.
  always @(negedge clk) begin
    if (o_rgb) n_rgb++;
    if (o_sob) n_sob++;
    if (o_access != last_acc) begin
      acc_hist = {acc_hist[29:0], o_access};
      n_chg++;
      last_acc = o_access;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    n_rgb = 0; n_sob = 0; n_chg = 0; acc_hist = '0;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return o_rgb;
      1:       return o_sob;
      2:       return o_done;
      default: return o_err;
    endcase
  endfunction

  task automatic wait_for(input int which, input int unsigned budget, output int unsigned n);
    n = 0;
    while (!sig(which) && n < budget) begin
      tick();
      n++;
    end
    if (!sig(which)) chk($sformatf("wait_sig%0d", which), 0, 1);
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // g: RUN_GRAY cycles before the gray edge (0 = never), s: RUN_SOBEL cycles (0 = never).
  task automatic run_job(input int unsigned g, input int unsigned s, input bit stale, input bit poke);
    int unsigned n, exp_cyc;
    bit          timeout;
    logic [31:0] exp_hist;
    clear_mon();
    gray_done = stale; sobel_done = 1'b0; color_loaded = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("load_state", o_state, 1);
    chk("load_busy", o_busy, 1);
    repeat ($urandom_range(0, 4)) tick();
    color_loaded = 1'b1;
    wait_for(0, 8, n);
    chk("gray_acc", o_access, ACC_GRAY);
    if (g == 0) begin
      wait_for(3, TO + 5, n);
      chk("gray_to_lat", n, TO + 1);
      timeout = 1'b1; exp_cyc = 1 + TO; exp_hist = 32'h4;
    end else begin
      for (int unsigned i = 1; i <= g; i++) begin
        tick();
        if (stale && i == g - 1) gray_done = 1'b0;
        if (poke && i == 1) start = 1'b1;
        if (poke && i == 2) start = 1'b0;
      end
      chk("gray_wait", o_state, 3);
      gray_done = 1'b1;
      wait_for(1, 4, n);
      chk("sob_lat", n, 1);
      chk("sob_acc", o_access, ACC_SOBEL);
      sobel_done = 1'b0;
      exp_hist = 32'h18;
      if (s == 0) begin
        wait_for(3, TO + 5, n);
        chk("sob_to_lat", n, TO + 1);
        timeout = 1'b1; exp_cyc = 2 + g + TO;
      end else begin
        repeat (s) tick();
        sobel_done = 1'b1;
        wait_for(2, 4, n);
        chk("done_lat", n, 1);
        timeout = 1'b0; exp_cyc = 2 + g + s;
      end
    end
    chk("cycles", o_cycles, sat(exp_cyc));
    chk("done_flag", o_done, !timeout);
    chk("err_flag", o_err, timeout);
    chk("state_end", o_state, timeout ? 7 : 6);
    chk("busy_end", o_busy, 0);
    chk("acc_end", o_access, ACC_HOST);
    if (timeout) chk("err_stage", o_err_stage, g != 0);
    repeat (3) tick();
    chk("cycles_hold", o_cycles, sat(exp_cyc));
    chk("n_rgb", n_rgb, 1);
    chk("n_sob", n_sob, (g != 0) ? 1 : 0);
    chk("acc_seq", acc_hist, exp_hist);
    chk("acc_chg", n_chg, (g != 0) ? 3 : 2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acc"},   o_access, 0);
    chk({tag, "_pulse"}, {o_rgb, o_sob}, 0);
    chk({tag, "_flags"}, {o_busy, o_done, o_err, o_err_stage}, 0);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_cyc"},   o_cycles, 0);
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    color_loaded = 1'b0; gray_done = 1'b0; sobel_done = 1'b0;
    clear_mon();
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst = 1'b0; tick();
    chk("idle_state", o_state, 0);

    repeat (5) run_job($urandom_range(2, 60), $urandom_range(1, 60), 1'b0, 1'b0);
    run_job($urandom_range(5, 50), $urandom_range(1, 40), 1'b1, 1'b0);
    run_job(3, TO, 1'b0, 1'b0);
    run_job($urandom_range(2, 20), 0, 1'b0, 1'b0);
    run_job(0, 0, 1'b0, 1'b0);
    run_job(90, 90, 1'b0, 1'b0);
    run_job(20, $urandom_range(1, 30), 1'b0, 1'b1);

    // Abort together with start while the gray stage runs.
    clear_mon();
    gray_done = 1'b0; color_loaded = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(0, 8, n);
    repeat (5) tick();
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("abort_state", o_state, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_acc", o_access, ACC_HOST);
    gray_done = 1'b1;
    repeat (5) tick();
    chk("abort_nosob", n_sob, 0);
    chk("abort_idle", o_state, 0);

    // Reset in RUN_SOBEL with a start request that must be dropped.
    gray_done = 1'b0; sobel_done = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wait_for(0, 8, n);
    repeat (4) tick();
    gray_done = 1'b1;
    wait_for(1, 4, n);
    repeat (5) tick();
    chk("pre_rst_state", o_state, 5);
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    chk_reset_outputs("midrst");
    tick();
    chk("rst_start_drop", o_state, 0);
    run_job($urandom_range(2, 40), $urandom_range(1, 40), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/img_pipe_sequencer.md
IMG_PIPE_SEQUENCER -- requirements
Module: img_pipe_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1048575, max cycles allowed in any RUN state before error.
REQ-002 Parameter CYC_W, default 24, width of performance cycle counter.
REQ-003 i_CLK  in  1  single clock; all logic on rising edge.
REQ-004 i_RST  in  1  reset, synchronous, active-high.
REQ-005 i_START  in  1  one-cycle command from AXI register: run full RGB->gray->Sobel sequence.
REQ-006 i_ABORT  in  1  one-cycle command: cancel sequence, return to IDLE.
REQ-007 i_COLOR_LOADED  in  1  level; color BRAM write complete (DONE_WRITE_COLOR_BRAM_SIGN).
REQ-008 i_GRAY_DONE  in  1  gray BRAM write complete (DONE_WRITE_GRAY_BRAM_SIGN).
REQ-009 i_SOBEL_DONE  in  1  Sobel processing complete (DONE_PROCESSING_SOBEL).
REQ-010 o_ACCESS_CONTROL  out  2  BRAM ownership select: 00 host/AXI, 01 RGB2GRAY, 10 GRAY2SOBEL; 11 never driven.
REQ-011 o_START_RGB2GRAY  out  1  one-cycle start pulse to RGB2GRAY.
REQ-012 o_START_GRAY2SOBEL  out  1  one-cycle start pulse to GRAY2SOBEL.
REQ-013 o_BUSY  out  1  high in every state except IDLE, DONE, ERR.
REQ-014 o_DONE  out  1  high while in DONE.
REQ-015 o_ERROR  out  1  high while in ERR.
REQ-016 o_ERR_STAGE  out  1  stage that timed out: 0 gray, 1 Sobel; valid while o_ERROR.
REQ-017 o_STATE  out  3  current state encoding, for status register.
REQ-018 o_CYCLES  out  CYC_W  processing cycle count of current/last run.

Function
REQ-019 States: IDLE, LOAD, START_GRAY, RUN_GRAY, START_SOBEL, RUN_SOBEL, DONE, ERR.
REQ-020 IDLE/DONE/ERR: i_START -> LOAD next cycle; o_CYCLES cleared, o_ERROR/o_DONE drop.
REQ-021 LOAD: ACCESS=00; i_COLOR_LOADED level high -> START_GRAY next cycle.
REQ-022 START_GRAY: exactly one cycle; o_START_RGB2GRAY=1, ACCESS=01 -> RUN_GRAY.
REQ-023 RUN_GRAY: ACCESS=01; rising edge of i_GRAY_DONE (registered previous sample low, current high) -> START_SOBEL.
REQ-024 START_SOBEL: exactly one cycle; o_START_GRAY2SOBEL=1, ACCESS=10 -> RUN_SOBEL.
REQ-025 RUN_SOBEL: ACCESS=10; rising edge of i_SOBEL_DONE -> DONE.
REQ-026 DONE and ERR: ACCESS=00, so host reads Sobel/gray BRAMs; held until i_START, i_ABORT or reset.
REQ-027 Done inputs already high on entering a RUN state do not advance; only fresh rising edge counts (stale level from previous run ignored).
REQ-028 Watchdog: counter cleared on entry to each RUN state, increments per RUN cycle; reaching TIMEOUT_CYCLES-1 with no done edge -> ERR next cycle, o_ERR_STAGE set.
REQ-029 Done edge and timeout in same cycle: done edge wins.
REQ-030 i_ABORT in any state -> IDLE next cycle, ACCESS=00, no start pulse issued; abort with i_START same cycle: abort wins.
REQ-031 i_START while o_BUSY ignored, no side effect.
REQ-032 o_CYCLES increments each cycle in START_GRAY..RUN_SOBEL, saturates at all-ones, held in DONE/ERR/IDLE.
REQ-033 All outputs registered; o_ACCESS_CONTROL changes in same cycle as start pulse it accompanies.

Reset
REQ-034 i_RST high at rising edge: state IDLE, ACCESS=00, both start pulses 0, o_BUSY/o_DONE/o_ERROR/o_ERR_STAGE 0, o_CYCLES 0, watchdog 0, edge registers 0.
REQ-035 Reset mid-run aborts without emitting any pulse; i_START in reset cycle is discarded.

Structure
REQ-036 Shared package img_pipe_pkg holds state enum typedef, ACCESS constants (ACC_HOST 00, ACC_GRAY 01, ACC_SOBEL 10), image constants (IMG_W 320, IMG_H 240, IMG_PIXELS 76800).
REQ-037 One sub-module pipe_watchdog: clear/enable inputs, TIMEOUT_CYCLES parameter, single-cycle expire output.

Verification
REQ-038 Normal run: start, COLOR_LOADED high, GRAY_DONE edge after 76800 cycles, SOBEL_DONE edge after 77000 -> ACCESS 00/01/10/00 sequence, one pulse each, o_DONE=1, o_CYCLES=153803 +/-2.
REQ-039 Stale done: GRAY_DONE held high from prior run -> sequencer waits in RUN_GRAY until low-then-high edge.
REQ-040 Timeout: TIMEOUT_CYCLES=100, no SOBEL_DONE -> ERR after 100 RUN_SOBEL cycles, o_ERR_STAGE=1, ACCESS=00.
REQ-041 Abort+start same cycle during RUN_GRAY -> IDLE, no START_GRAY2SOBEL pulse, o_BUSY=0.
REQ-042 Reset asserted in RUN_SOBEL -> all outputs at reset values next cycle; new start then completes normally.
REQ-043 Start while busy -> no restart, o_CYCLES unchanged.
